skinny_sbox8_ti2_inv_reshare_ctrl: RTL and testbench

- 3-share threshold implementation of the SKINNY-128 8-bit inverse S-box, used by the decryption datapath.
- It is the decrypt-side counterpart of the team's forward TI2 resharing S-box. It uses the same NOR-XOR gate type and the same resharing, with the gate network reversed.
- The datapath has 4 registered gate layers. A valid/ready controller allows one operation in flight and holds the result until it is consumed.
- The unmasked value (XOR of the 3 shares) of bo0^bo1^bo2 equals S8^-1 of si0^si1^si2.

---
 rtl/skinny_sbox8_ti2_inv_reshare_ctrl.sv | 126 ++++++++++++
 tb/tb_skinny_sbox8_ti2_inv_reshare_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/skinny_sbox8_ti2_inv_reshare_ctrl.sv
// Three-share threshold SKINNY-128 inverse 8-bit S-box: four registered NOR-XOR
// gate layers with fresh resharing randomness, under a one-in-flight valid/ready controller.
module skinny_sbox8_ti2_inv_reshare_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  si0,
  input  logic [7:0]  si1,
  input  logic [7:0]  si2,
  input  logic [23:0] r,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  bo0,
  output logic [7:0]  bo1,
  output logic [7:0]  bo2
);

  localparam int unsigned NBITS  = 8;
  localparam int unsigned NGATES = 8;

  typedef enum logic [2:0] {IDLE, L1, L2, L3, L4, DONE} state_t;

  state_t                        state;
  logic [NBITS-1:0]              s0_q, s1_q, s2_q;
  logic [NBITS-1:0][2:0]         o;
  logic [NGATES-1:0][2:0]        gd;
  logic [NGATES-1:0][2:0]        gq;
  logic [NBITS-1:0][2:0]         b;

  // Shared gate: z ^ NOR(a,b) on 3-share bits, products re-masked with 3 fresh bits.
  function automatic logic [2:0] ti_gate(input logic [2:0] a, input logic [2:0] bb,
                                         input logic [2:0] z, input logic [2:0] rr);
    logic [2:0] x, y, f;
    x = a ^ 3'b001;
    y = bb ^ 3'b001;
    f[0] = (x[1] & y[1]) ^ (x[1] & y[2]) ^ (x[2] & y[1]) ^ z[0] ^ rr[0] ^ rr[1];
    f[1] = (x[2] & y[2]) ^ (x[0] & y[2]) ^ (x[2] & y[0]) ^ z[1] ^ rr[1] ^ rr[2];
    f[2] = (x[0] & y[0]) ^ (x[0] & y[1]) ^ (x[1] & y[0]) ^ z[2] ^ rr[2] ^ rr[0];
    return f;
  endfunction

  always_comb begin
    for (int i = 0; i < NBITS; i++) begin
      o[i] = {s2_q[i], s1_q[i], s0_q[i]};
    end
  end

  assign gd[0] = ti_gate(o[3],  o[1],  o[0], r[2:0]);
  assign gd[1] = ti_gate(o[7],  o[6],  o[4], r[5:3]);
  assign gd[2] = ti_gate(o[2],  o[7],  o[1], r[8:6]);
  assign gd[3] = ti_gate(o[6],  o[5],  o[7], r[11:9]);
  assign gd[4] = ti_gate(o[5],  gq[1], o[3], r[14:12]);
  assign gd[5] = ti_gate(gq[1], gq[0], o[5], r[17:15]);
  assign gd[6] = ti_gate(gq[0], gq[4], o[2], r[20:18]);
  assign gd[7] = ti_gate(gq[2], gq[6], o[6], r[23:21]);

  // Controller: one operation in flight, result held until consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      s0_q      <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            s0_q     <= si0;
            s1_q     <= si1;
            s2_q     <= si2;
            in_ready <= 1'b0;
            state    <= L1;
          end
        end
        L1: state <= L2;
        L2: state <= L3;
        L3: state <= L4;
        L4: begin
          state     <= DONE;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  // Only the active layer's registers load, so r is consumed in L1..L4 only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gq <= '0;
    end else begin
      case (state)
        L1:      gq[3:0] <= gd[3:0];
        L2:      gq[5:4] <= gd[5:4];
        L3:      gq[6]   <= gd[6];
        L4:      gq[7]   <= gd[7];
        default: ;
      endcase
    end
  end

  assign b = {gq[2], gq[6], gq[3], gq[7], gq[1], gq[0], gq[4], gq[5]};

  always_comb begin
    for (int i = 0; i < NBITS; i++) begin
      bo0[i] = b[i][0];
      bo1[i] = b[i][1];
      bo2[i] = b[i][2];
    end
  end

endmodule

// File: tb/tb_skinny_sbox8_ti2_inv_reshare_ctrl.sv
// Scoreboard bench for the masked SKINNY-128 inverse S-box: random shares and r,
// reference inverse built by inverting a forward S-box model.
module tb_skinny_sbox8_ti2_inv_reshare_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  si0, si1, si2;
  logic [23:0] r;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  bo0, bo1, bo2;

  typedef struct {
    logic [7:0] val;
    int         due;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  bit         r_zero = 1'b0;
  logic [7:0] inv_tab [256];
  int         last_acc;

  skinny_sbox8_ti2_inv_reshare_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .si0(si0), .si1(si1), .si2(si2), .r(r),
    .out_valid(out_valid), .out_ready(out_ready),
    .bo0(bo0), .bo1(bo1), .bo2(bo2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Forward SKINNY-128 S-box: undo each NOR-XOR step of the inverse in reverse order.
  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] y;
    y = '0;
    y[6] = x[4] ^ ~(x[7] | x[6]);
    y[2] = x[6] ^ ~(x[2] | x[1]);
    y[5] = x[0] ^ ~(x[3] | x[2]);
    y[3] = x[1] ^ ~(y[5] | x[3]);
    y[7] = x[5] ^ ~(y[6] | y[5]);
    y[1] = x[7] ^ ~(y[2] | y[7]);
    y[4] = x[3] ^ ~(y[7] | y[6]);
    y[0] = x[2] ^ ~(y[3] | y[1]);
    return y;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out / unexpected at cyc %0d", name, cyc);
  endtask

  // Fresh randomness every cycle unless the zero-mask phase forces it to 0.
  initial begin
    r = '0;
    forever begin
      @(posedge clk);
      #1;
      r = r_zero ? 24'd0 : 24'($urandom());
    end
  end

  // Monitor: latency at each rising out_valid, data at each handshake.
  initial begin
    bit   prev_v, prev_hs;
    exp_t e;
    prev_v  = 1'b0;
    prev_hs = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v  = 1'b0;
        prev_hs = 1'b0;
      end else begin
        if (prev_hs) begin
          chk("pulse_width", 32'(out_valid), 32'd0);
          chk("idle_after_hs", 32'(in_ready), 32'd1);
        end
        if (out_valid && !prev_v) begin
          if (sb.size() == 0) fail_now("spurious_out_valid");
          else chk("latency", 32'(cyc), 32'(sb[0].due));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) fail_now("unexpected_result");
          else begin
            e = sb.pop_front();
            chk("unmasked_out", 32'(bo0 ^ bo1 ^ bo2), 32'(e.val));
          end
        end
        prev_hs = out_valid && out_ready;
        prev_v  = out_valid;
      end
    end
  end

  // Present one value once in_ready is seen; it is accepted on the next edge.
  task automatic issue(input logic [7:0] v, input logic [7:0] expv, input bit masked,
                       input bit keep_valid, input bit push, output int acc);
    int n;
    n = 0;
    acc = -1;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      fail_now("in_ready_wait");
      return;
    end
    in_valid = 1'b1;
    if (masked) begin
      si0 = 8'($urandom());
      si1 = 8'($urandom());
      si2 = v ^ si0 ^ si1;
    end else begin
      si0 = v;
      si1 = 8'd0;
      si2 = 8'd0;
    end
    acc = cyc;
    if (push) sb.push_back('{val: expv, due: cyc + 5});
    @(posedge clk);
    #1;
    in_valid = keep_valid;
    si0 = 8'($urandom());
    si1 = 8'($urandom());
    si2 = 8'($urandom());
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0 || !in_ready) fail_now("drain");
  endtask

  initial begin
    int         acc;
    int         n;
    logic [7:0] v, s0s, s1s, s2s;

    for (int i = 0; i < 256; i++) inv_tab[sbox_fwd(8'(i))] = 8'(i);

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    si0 = '0; si1 = '0; si2 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_bo", 32'({bo0, bo1, bo2}), 32'd0);
    @(posedge clk);
    #1;

    // Zero masks and zero randomness, known S-box points.
    r_zero = 1'b1;
    issue(8'h65, 8'h00, 1'b0, 1'b0, 1'b1, acc);
    issue(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, acc);
    issue(8'h4C, 8'h01, 1'b0, 1'b0, 1'b1, acc);
    drain();
    r_zero = 1'b0;

    // Exhaustive sweep, in_valid held high: checks issue period and ignored inputs.
    last_acc = -1;
    for (int i = 0; i < 256; i++) begin
      issue(8'(i), inv_tab[i], 1'b1, 1'b1, 1'b1, acc);
      if (last_acc >= 0 && acc >= 0) chk("issue_period", 32'(acc - last_acc), 32'd6);
      last_acc = acc;
    end
    in_valid = 1'b0;
    drain();

    // Backpressure with toggling r, in_valid and si while DONE is held.
    out_ready = 1'b0;
    v = 8'($urandom());
    issue(v, inv_tab[v], 1'b1, 1'b0, 1'b1, acc);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) fail_now("bp_wait_valid");
    s0s = bo0; s1s = bo1; s2s = bo2;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'($urandom());
      si0 = 8'($urandom());
      si1 = 8'($urandom());
      si2 = 8'($urandom());
      @(posedge clk);
      #1;
      chk("bp_bo0", 32'(bo0), 32'(s0s));
      chk("bp_bo1", 32'(bo1), 32'(s1s));
      chk("bp_bo2", 32'(bo2), 32'(s2s));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Asynchronous reset in the middle of L2: operation discarded, no output.
    v = 8'($urandom());
    issue(v, inv_tab[v], 1'b1, 1'b0, 1'b0, acc);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_bo", 32'({bo0, bo1, bo2}), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      chk("arst_no_valid", 32'(out_valid), 32'd0);
    end

    for (int k = 0; k < 6; k++) begin
      v = 8'($urandom());
      issue(v, inv_tab[v], 1'b1, 1'b0, 1'b1, acc);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
